// File: rtl/te_pkg.sv
// te_pkg: shared state type and beat-width helpers for the transfer engine
package te_pkg;
   typedef enum logic [1:0] {IDLE, ARB, XFER} merge_state_t;
   function automatic int arsize(input int mem_width);
      return $clog2(mem_width / 8);
   endfunction
   function automatic int len_width(input int addr_width, input int mem_width);
      return addr_width - arsize(mem_width);
   endfunction
endpackage

// File: rtl/axis_skid_reg.sv
// axis_skid_reg: 2-entry registered AXI-Stream slice; full throughput, outputs held while stalled
module axis_skid_reg #(
   parameter int DWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DWIDTH-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [DWIDTH-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready
);
   logic [DWIDTH-1:0] buf_data;
   logic              buf_valid;
   assign s_ready = !buf_valid;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         m_data    <= '0;
         m_valid   <= 1'b0;
         buf_data  <= '0;
         buf_valid <= 1'b0;
      end else if (m_ready || !m_valid) begin
         m_valid   <= buf_valid || s_valid;
         m_data    <= buf_valid ? buf_data : s_valid ? s_data : m_data;
         buf_valid <= 1'b0;
      end else if (s_valid && s_ready) begin
         buf_data  <= s_data;
         buf_valid <= 1'b1;
      end
endmodule

// File: rtl/channel_merge.sv
// channel_merge: round-robin, packet-granular merge of per-channel read streams into one
// AXI-Stream tagged with tdest; done pulses once every channel's beat budget has left the skid.
module channel_merge
   import te_pkg::*;
#(
   parameter int MEM_WIDTH  = 512,
   parameter int ADDR_WIDTH = 64,
   parameter int N_CHANNELS = 16,
   parameter int PKT_BEATS  = 64
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [N_CHANNELS-1:0][ADDR_WIDTH-1:0] rd_size,
   input  logic                                  start,
   output logic                                  busy,
   output logic                                  done,
   input  logic [N_CHANNELS-1:0][MEM_WIDTH-1:0]  channel_tdata,
   input  logic [N_CHANNELS-1:0]                 channel_tvalid,
   output logic [N_CHANNELS-1:0]                 channel_tready,
   output logic [MEM_WIDTH-1:0]                  m_axis_tdata,
   output logic [3:0]                            m_axis_tdest,
   output logic                                  m_axis_tlast,
   output logic                                  m_axis_tvalid,
   input  logic                                  m_axis_tready
);
   localparam int BSH = arsize(MEM_WIDTH);
   localparam int RW  = len_width(ADDR_WIDTH, MEM_WIDTH);
   localparam int BW  = $clog2(PKT_BEATS);
   localparam int GW  = N_CHANNELS > 1 ? $clog2(N_CHANNELS) : 1;

   merge_state_t                 state, state_n;
   logic [N_CHANNELS-1:0][RW-1:0] rem;
   logic [N_CHANNELS-1:0]        cand;
   logic [GW-1:0]                ptr, g, pick, hi_pick, lo_pick;
   logic [BW-1:0]                beat_cnt;
   logic                         hi_found, found, all_zero, load_zero, last, in_valid, in_ready, beat, empty_n;

   always_comb begin
      cand      = '0;
      all_zero  = 1'b1;
      load_zero = 1'b1;
      hi_found  = 1'b0;
      hi_pick   = '0;
      lo_pick   = '0;
      // descending scan leaves the lowest candidate at/after ptr, else the lowest overall
      for (int i = N_CHANNELS - 1; i >= 0; i--) begin
         cand[i]   = rem[i] != '0 && channel_tvalid[i];
         all_zero  = all_zero && rem[i] == '0;
         load_zero = load_zero && rd_size[i][ADDR_WIDTH-1:BSH] == '0;
         if (cand[i]) begin
            lo_pick = GW'(i);
            if (i >= int'(ptr)) begin
               hi_found = 1'b1;
               hi_pick  = GW'(i);
            end
         end
      end
      found             = |cand;
      pick              = hi_found ? hi_pick : lo_pick;
      last              = beat_cnt == BW'(PKT_BEATS - 1) || rem[g] == RW'(1);
      in_valid          = state == XFER && channel_tvalid[g];
      beat              = in_valid && in_ready;
      channel_tready    = '0;
      channel_tready[g] = state == XFER && in_ready;
      // skid drains this cycle: no buffered entry and the output register empties or fires
      empty_n           = in_ready && (!m_axis_tvalid || m_axis_tready);
      state_n           = state == IDLE ? (start && !load_zero ? ARB : IDLE) :
                          state == ARB  ? (found ? XFER : all_zero && empty_n ? IDLE : ARB) :
                                          (beat && last ? ARB : XFER);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= IDLE;
         rem      <= '0;
         ptr      <= '0;
         g        <= '0;
         beat_cnt <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state <= state_n;
         busy  <= state_n != IDLE;
         done  <= (state == IDLE && start && load_zero) || (state == ARB && !found && all_zero && empty_n);
         if (state == IDLE && start)
            for (int i = 0; i < N_CHANNELS; i++) rem[i] <= rd_size[i][ADDR_WIDTH-1:BSH];
         if (state == ARB && found) g <= pick;
         if (beat) begin
            rem[g]   <= rem[g] - RW'(1);
            beat_cnt <= last ? '0 : beat_cnt + BW'(1);
            if (last) ptr <= g == GW'(N_CHANNELS - 1) ? '0 : g + GW'(1);
         end
      end

   axis_skid_reg #(.DWIDTH(MEM_WIDTH + 5)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .s_data  ({channel_tdata[g], 4'(g), last}),
      .s_valid (in_valid),
      .s_ready (in_ready),
      .m_data  ({m_axis_tdata, m_axis_tdest, m_axis_tlast}),
      .m_valid (m_axis_tvalid),
      .m_ready (m_axis_tready)
   );
endmodule

// File: tb/tb_channel_merge.sv
// tb_channel_merge: randomized and directed checks of channel_merge against a packet-level
// model (per-channel budgets, round-robin pointer, expected data queues).
module tb_channel_merge;
   localparam int N = 4, PB = 4, MW = 512, AW = 64, BYTES = MW / 8;

   logic                  clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic                  busy, done;
   logic [N-1:0][AW-1:0]  rd_size = '0;
   logic [N-1:0][MW-1:0]  channel_tdata = '0;
   logic [N-1:0]          channel_tvalid = '0, channel_tready;
   logic [MW-1:0]         m_axis_tdata;
   logic [3:0]            m_axis_tdest;
   logic                  m_axis_tlast, m_axis_tvalid, m_axis_tready = 1'b0;

   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   channel_merge #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW), .N_CHANNELS(N), .PKT_BEATS(PB)) dut (
      .clk            (clk),
      .rst            (rst),
      .rd_size        (rd_size),
      .start          (start),
      .busy           (busy),
      .done           (done),
      .channel_tdata  (channel_tdata),
      .channel_tvalid (channel_tvalid),
      .channel_tready (channel_tready),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tdest   (m_axis_tdest),
      .m_axis_tlast   (m_axis_tlast),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready)
   );

   task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [MW-1:0] src_q[N][$];
   logic [MW-1:0] exp_q[N][$];
   int            mrem[N];
   int            mptr = 0, pkt_len = 0, cur = 0, done_cnt = 0;
   bit            done_pend = 0, prev_stall = 0, rr_chk = 1, all_valid = 1, rand_ready = 0;
   logic [MW-1:0] prev_data;
   logic [5:0]    prev_meta;
   logic [N-1:0]  in_hs = '0;
   int            log_d[$], log_l[$];

   // reference model: sampled mid-cycle, consumes each merged handshake
   always @(negedge clk) begin
      int d, e;
      bit ok, lst;
      if (rst) begin
         foreach (mrem[c]) mrem[c] = 0;
         mptr = 0; pkt_len = 0; done_pend = 0; prev_stall = 0; in_hs = '0;
      end else begin
         check("done", done, done_pend);
         done_pend = 0;
         if (done) done_cnt++;
         if (prev_stall) begin
            check("hold_data", m_axis_tdata, prev_data);
            check("hold_meta", {m_axis_tvalid, m_axis_tdest, m_axis_tlast}, prev_meta);
         end
         if (start && !busy) begin
            foreach (mrem[c]) mrem[c] = int'(rd_size[c] / BYTES);
            if (mrem.sum() == 0) done_pend = 1;
         end
         in_hs = channel_tvalid & channel_tready;
         if (m_axis_tvalid && m_axis_tready) begin
            d = int'(m_axis_tdest);
            if (pkt_len == 0 && rr_chk) begin
               e = -1;
               for (int k = N - 1; k >= 0; k--) if (mrem[(mptr + k) % N] > 0) e = (mptr + k) % N;
               check("rr_dest", d, e);
            end
            if (pkt_len != 0) check("pkt_dest", d, cur);
            ok = d < N && mrem[d] > 0;
            check("dest_budget", ok, 1);
            if (ok) begin
               lst = pkt_len + 1 == PB || mrem[d] == 1;
               check("tdata", m_axis_tdata, exp_q[d].pop_front());
               check("tlast", m_axis_tlast, lst);
               mrem[d]--; pkt_len++; cur = d;
               if (lst) begin
                  log_d.push_back(d); log_l.push_back(pkt_len);
                  pkt_len = 0; mptr = (d + 1) % N;
               end
               if (mrem.sum() == 0) done_pend = 1;
            end
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_data  = m_axis_tdata;
         prev_meta  = {m_axis_tvalid, m_axis_tdest, m_axis_tlast};
      end
   end

   // per-channel sources: hold valid until accepted, then present the next word
   always @(posedge clk) begin
      #1;
      if (rst) channel_tvalid = '0;
      else begin
         for (int c = 0; c < N; c++) begin
            if (in_hs[c]) void'(src_q[c].pop_front());
            if (!channel_tvalid[c] || in_hs[c]) begin
               channel_tvalid[c] = src_q[c].size() > 0 && (all_valid || $urandom_range(1) == 1);
               channel_tdata[c]  = src_q[c].size() > 0 ? src_q[c][0] : '0;
            end
         end
         m_axis_tready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
      end
   end

   task automatic prep(input int unsigned sz[N]);
      logic [MW-1:0] w;
      log_d.delete(); log_l.delete();
      for (int c = 0; c < N; c++) begin
         rd_size[c] = AW'(sz[c]);
         for (int b = 0; b < int'(sz[c]) / BYTES; b++) begin
            for (int k = 0; k < MW / 32; k++) w[k*32 +: 32] = $urandom;
            src_q[c].push_back(w);
            exp_q[c].push_back(w);
         end
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic pulse();
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int base, n;
      base = done_cnt; n = 0;
      while (done_cnt == base && n < 3000) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      check({tag, "_done_cnt"}, done_cnt - base, 1);
   endtask

   task automatic chk_log(input string tag, input int ed[$], input int el[$]);
      check({tag, "_npkt"}, log_d.size(), ed.size());
      foreach (ed[i]) if (i < log_d.size()) begin
         check({tag, "_dest"}, log_d[i], ed[i]);
         check({tag, "_len"}, log_l[i], el[i]);
      end
   endtask

   initial begin
      int unsigned sz[N];
      int ed[$], el[$];
      int tot, got;
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ready", channel_tready, 0);
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tlast", m_axis_tlast, 0);
      check("rst_tdest", m_axis_tdest, 0);
      check("rst_tdata", m_axis_tdata, 0);
      @(posedge clk);
      #2 rst = 1'b0;

      sz = '{256, 256, 256, 256};
      prep(sz); pulse(); wait_done("t1");
      ed = '{0, 1, 2, 3}; el = '{4, 4, 4, 4}; chk_log("t1", ed, el);

      sz = '{640, 0, 0, 0};
      prep(sz); pulse(); wait_done("t2");
      ed = '{0, 0, 0}; el = '{4, 4, 2}; chk_log("t2", ed, el);

      sz = '{0, 640, 640, 0};
      prep(sz); pulse(); wait_done("t3");
      ed = '{1, 2, 1, 2, 1, 2}; el = '{4, 4, 4, 4, 2, 2}; chk_log("t3", ed, el);

      sz = '{256, 256, 0, 0};
      prep(sz); pulse();
      @(posedge clk);
      #1 rd_size[0] = AW'(640); rd_size[2] = AW'(640); start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("t6_busy_held", busy, 1);
      wait_done("t6a");
      ed = '{0, 1}; el = '{4, 4}; chk_log("t6a", ed, el);

      sz = '{100, 0, 0, 0};
      prep(sz); pulse(); wait_done("t6b");
      ed = '{0}; el = '{1}; chk_log("t6b", ed, el);

      sz = '{0, 0, 0, 0};
      prep(sz); pulse();
      check("t6_zero_busy", busy, 0);
      wait_done("t6c");

      rr_chk = 0; all_valid = 0; rand_ready = 1;
      for (int it = 0; it < 4; it++) begin
         tot = 0;
         foreach (sz[c]) begin
            sz[c] = $urandom_range(0, 12) * BYTES + $urandom_range(0, BYTES - 1);
            tot += int'(sz[c]) / BYTES;
         end
         prep(sz); pulse(); wait_done("t4");
         got = log_l.sum();
         check("t4_beats", got, tot);
         got = 0;
         foreach (exp_q[c]) got += exp_q[c].size();
         check("t4_drained", got, 0);
      end
      rr_chk = 1; all_valid = 1; rand_ready = 0;

      sz = '{512, 512, 512, 512};
      prep(sz); pulse();
      repeat (8) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t5_tvalid", m_axis_tvalid, 0);
      check("t5_tlast", m_axis_tlast, 0);
      check("t5_tdest", m_axis_tdest, 0);
      check("t5_tdata", m_axis_tdata, 0);
      check("t5_busy", busy, 0);
      check("t5_ready", channel_tready, 0);
      for (int c = 0; c < N; c++) begin
         src_q[c].delete();
         exp_q[c].delete();
      end
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      sz = '{256, 256, 256, 256};
      prep(sz); pulse(); wait_done("t5");
      ed = '{0, 1, 2, 3}; el = '{4, 4, 4, 4}; chk_log("t5", ed, el);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
